// File: rtl/video_if_ctrl_if.sv
// Control/status and video-timing bundle for video_if_ctrl.
// master = system control / video source side, slave = the controller itself.
interface video_if_ctrl_if #(
  parameter int CNT_W = 12
);
  logic             start;
  logic             stop;
  logic             vs_i;
  logic             hs_i;
  logic             de_i;
  logic             en_o;
  logic             locked_o;
  logic             busy_o;
  logic [CNT_W-1:0] h_active_o;
  logic [CNT_W-1:0] v_active_o;
  logic             err_o;
  logic             timeout_o;
  logic [15:0]      frame_cnt_o;

  modport master (
    output start, stop, vs_i, hs_i, de_i,
    input  en_o, locked_o, busy_o, h_active_o, v_active_o, err_o, timeout_o, frame_cnt_o
  );

  modport slave (
    input  start, stop, vs_i, hs_i, de_i,
    output en_o, locked_o, busy_o, h_active_o, v_active_o, err_o, timeout_o, frame_cnt_o
  );
endinterface

// File: rtl/video_if_ctrl.sv
// Frame-level sequencer: measures active geometry per frame and enables capture after a lock.
// Optional frame counter is built only when VIDEO_IF_CTRL_FRAME_CNT_EN is defined.
module video_if_ctrl #(
  parameter int          CNT_W       = 12,
  parameter int          LOCK_FRAMES = 3,
  parameter logic [23:0] TIMEOUT     = 24'd2_000_000
) (
  input  logic          clk,
  input  logic          rst,
  video_if_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEEK,
    ST_MEASURE,
    ST_VERIFY,
    ST_LOCKED
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_FRAMES);

  // Input registers
  logic vs_q, vs_q2, hs_q, hs_q2, de_q, de_q2;
  logic vs_rise, de_fall;

  // Per-frame measurement
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0] first_len_q, first_len_d;
  logic             mism_q, mism_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] fr_h, fr_v;
  logic             fr_valid;
  logic             frame_match;

  // Signal-loss watchdog
  logic [23:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_hit;

  // Sequencer
  state_e           state_q;
  logic             en_q, locked_q, busy_q, err_q, tmo_flag_q, stop_pend_q;
  logic [CNT_W-1:0] h_ref_q, v_ref_q;
  logic [3:0]       match_q, match_nx;
  logic             stop_now, start_ok;
  logic             fcnt_inc, fcnt_clr;

  // HS is carried through the input pipeline only; geometry is taken from DE.
  logic unused_hs;
  assign unused_hs = hs_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q  <= 1'b0;
      vs_q2 <= 1'b0;
      hs_q  <= 1'b0;
      hs_q2 <= 1'b0;
      de_q  <= 1'b0;
      de_q2 <= 1'b0;
    end else begin
      vs_q  <= bus.vs_i;
      vs_q2 <= vs_q;
      hs_q  <= bus.hs_i;
      hs_q2 <= hs_q;
      de_q  <= bus.de_i;
      de_q2 <= de_q;
    end
  end

  assign vs_rise = vs_q & ~vs_q2;
  assign de_fall = ~de_q & de_q2;

  // A line closing in the same cycle as vs_rise still belongs to the finishing frame;
  // a line still open at vs_rise carries its pixel count into the new frame.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it unassigned (no latch).
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    first_len_d = first_len_q;
    mism_d      = mism_q;
    sat_d       = sat_q;
    if (de_fall) begin
      pix_cnt_d = '0;
      if (line_cnt_q != CNT_MAX) line_cnt_d = line_cnt_q + 1'b1;
      if (line_cnt_q == '0)               first_len_d = pix_cnt_q;
      else if (pix_cnt_q != first_len_q)  mism_d      = 1'b1;
      if (pix_cnt_q == CNT_MAX) sat_d = 1'b1;
    end else if (de_q && (pix_cnt_q != CNT_MAX)) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
    end
    fr_h     = first_len_d;
    fr_v     = line_cnt_d;
    fr_valid = (line_cnt_d != '0) && (line_cnt_d != CNT_MAX) && !sat_d && !mism_d;
    if (vs_rise) begin
      line_cnt_d  = '0;
      first_len_d = '0;
      mism_d      = 1'b0;
      sat_d       = 1'b0;
    end
  end

  assign frame_match = fr_valid && (fr_h == h_ref_q) && (fr_v == v_ref_q);
  assign match_nx    = frame_match ? (match_q + 4'd1) : {3'b000, fr_valid};

  // VS rise counts as signal present even if it lands on the expiry cycle.
  assign tmo_hit = (state_q != ST_IDLE) && !vs_rise && (tmo_cnt_q == TIMEOUT);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q + 24'd1;
    if ((state_q == ST_IDLE) || vs_rise || tmo_hit) tmo_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with <= only, so every register samples pre-edge values.
    if (rst) begin
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      first_len_q <= '0;
      mism_q      <= 1'b0;
      sat_q       <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      first_len_q <= first_len_d;
      mism_q      <= mism_d;
      sat_q       <= sat_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign start_ok = (state_q == ST_IDLE) && bus.start && !bus.stop;
  assign stop_now = stop_pend_q | bus.stop;
  assign fcnt_clr = start_ok;
  assign fcnt_inc = (state_q == ST_LOCKED) && vs_rise && !stop_now && frame_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      en_q        <= 1'b0;
      locked_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      tmo_flag_q  <= 1'b0;
      stop_pend_q <= 1'b0;
      h_ref_q     <= '0;
      v_ref_q     <= '0;
      match_q     <= '0;
    end else if (state_q == ST_IDLE) begin
      if (start_ok) begin
        state_q    <= ST_SEEK;
        busy_q     <= 1'b1;
        err_q      <= 1'b0;
        tmo_flag_q <= 1'b0;
        h_ref_q    <= '0;
        v_ref_q    <= '0;
        match_q    <= '0;
      end
    end else if (tmo_hit) begin
      // Signal loss overrides everything; a pending stop still sends us home.
      en_q        <= 1'b0;
      locked_q    <= 1'b0;
      tmo_flag_q  <= 1'b1;
      stop_pend_q <= 1'b0;
      match_q     <= '0;
      if (stop_now) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        state_q <= ST_SEEK;
      end
    end else if (bus.stop && (state_q != ST_LOCKED)) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      match_q <= '0;
    end else begin
      case (state_q)
        ST_SEEK: begin
          if (vs_rise) state_q <= ST_MEASURE;
        end
        ST_MEASURE: begin
          if (vs_rise && fr_valid) begin
            h_ref_q <= fr_h;
            v_ref_q <= fr_v;
            match_q <= 4'd1;
            if (LOCK_N == 4'd1) begin
              state_q  <= ST_LOCKED;
              en_q     <= 1'b1;
              locked_q <= 1'b1;
            end else begin
              state_q <= ST_VERIFY;
            end
          end
        end
        ST_VERIFY: begin
          if (vs_rise) begin
            if (!frame_match) begin
              h_ref_q <= fr_h;
              v_ref_q <= fr_v;
            end
            match_q <= match_nx;
            if (match_nx == LOCK_N) begin
              state_q  <= ST_LOCKED;
              en_q     <= 1'b1;
              locked_q <= 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (vs_rise) begin
            if (stop_now) begin
              state_q     <= ST_IDLE;
              en_q        <= 1'b0;
              locked_q    <= 1'b0;
              busy_q      <= 1'b0;
              stop_pend_q <= 1'b0;
              match_q     <= '0;
            end else if (!frame_match) begin
              state_q  <= ST_VERIFY;
              en_q     <= 1'b0;
              locked_q <= 1'b0;
              err_q    <= 1'b1;
              h_ref_q  <= fr_h;
              v_ref_q  <= fr_v;
              match_q  <= {3'b000, fr_valid};
            end
          end else if (bus.stop) begin
            stop_pend_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef VIDEO_IF_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || fcnt_clr) frame_cnt_q <= '0;
    else if (fcnt_inc)   frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign bus.frame_cnt_o = frame_cnt_q;
`else
  logic unused_fcnt;
  assign unused_fcnt     = fcnt_inc ^ fcnt_clr;
  assign bus.frame_cnt_o = '0;
`endif

  assign bus.en_o       = en_q;
  assign bus.locked_o   = locked_q;
  assign bus.busy_o     = busy_q;
  assign bus.err_o      = err_q;
  assign bus.timeout_o  = tmo_flag_q;
  assign bus.h_active_o = h_ref_q;
  assign bus.v_active_o = v_ref_q;

endmodule
